// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel programmable clock divider.
package clk_div_pkg;

  localparam int unsigned DIV_W_DEF = 16;

  // Reset divisor derived from input and default output frequencies
  function automatic int unsigned def_div(input int unsigned clk_f, input int unsigned sc_f);
    return clk_f / sc_f;
  endfunction

  // Divisors below 2 cannot form a square wave; force them up to 2
  function automatic logic [31:0] div_clamp(input logic [31:0] d);
    return (d < 32'd2) ? 32'd2 : d;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// Single divider channel: period counter, square wave, tick strobe and
// boundary-aligned divisor update.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W   = DIV_W_DEF,
  parameter int unsigned DEF_DIV = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             ld,
  input  logic [DIV_W-1:0] div_in,
  output logic             sc,
  output logic             tick,
  output logic             pend
);

  localparam logic [DIV_W-1:0] DEF_DIV_L = DIV_W'(DEF_DIV);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] div_pend;
  logic [DIV_W-1:0] half_c;
  logic [DIV_W-1:0] cnt_nxt_c;
  logic [DIV_W-1:0] div_in_clamp_c;
  logic [DIV_W-1:0] div_pend_clamp_c;
  logic             wrap_c;

  assign half_c           = div_act >> 1;
  assign cnt_nxt_c        = cnt + DIV_W'(1);
  assign div_in_clamp_c   = DIV_W'(div_clamp(32'(div_in)));
  assign div_pend_clamp_c = DIV_W'(div_clamp(32'(div_pend)));
  assign wrap_c           = en && (sync || (cnt == div_act - DIV_W'(1)));

  // A load coincident with a wrap bypasses the pending register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= DEF_DIV_L - DIV_W'(1);
      div_act  <= DEF_DIV_L;
      div_pend <= '0;
      pend     <= 1'b0;
      sc       <= 1'b0;
      tick     <= 1'b0;
    end else begin
      if (ld && !wrap_c) begin
        div_pend <= div_in;
        pend     <= 1'b1;
      end
      if (wrap_c) begin
        cnt  <= '0;
        sc   <= 1'b1;
        tick <= 1'b1;
        pend <= 1'b0;
        if (ld)
          div_act <= div_in_clamp_c;
        else if (pend)
          div_act <= div_pend_clamp_c;
      end else if (en) begin
        cnt  <= cnt_nxt_c;
        sc   <= (cnt_nxt_c < half_c);
        tick <= 1'b0;
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independently programmable clock divider channels sharing a
// phase-alignment sync input.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned DIV_W = DIV_W_DEF,
  parameter int unsigned CLK_F = 40_000_000,
  parameter int unsigned SC_F  = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic [N_CH-1:0]  ld,
  input  logic [DIV_W-1:0] div_in,
  output logic [N_CH-1:0]  sc,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  pend
);

  localparam int unsigned DEF_DIV = def_div(CLK_F, SC_F);

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    clk_div_ch #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .en     (en[i]),
      .sync   (sync),
      .ld     (ld[i]),
      .div_in (div_in),
      .sc     (sc[i]),
      .tick   (tick[i]),
      .pend   (pend[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank against a period/phase reference model.
module tb_clk_div_bank;

  localparam int unsigned NC  = 2;
  localparam int unsigned DW  = 16;
  localparam int          DEF = 40;

  typedef struct packed {
    logic [NC-1:0] sc;
    logic [NC-1:0] tick;
    logic [NC-1:0] pend;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NC-1:0] en = '0;
  logic          sync = 1'b0;
  logic [NC-1:0] ld = '0;
  logic [DW-1:0] div_in = '0;
  logic [NC-1:0] sc, tick, pend;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  // Reference model: position within the current period and period length
  int age [NC];
  int per [NC];
  int pval[NC];
  bit pnd [NC];
  bit msc [NC];
  bit mtk [NC];

  clk_div_bank #(.N_CH(NC), .DIV_W(DW), .CLK_F(40_000_000), .SC_F(1_000_000)) dut (
    .clk(clk), .reset(reset), .en(en), .sync(sync), .ld(ld),
    .div_in(div_in), .sc(sc), .tick(tick), .pend(pend)
  );

  always #5 clk = ~clk;

  function automatic int clampv(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic cycle(input logic rst, input logic [NC-1:0] e, input logic s,
                       input logic [NC-1:0] l, input logic [DW-1:0] d);
    exp_t x;
    reset = rst; en = e; sync = s; ld = l; div_in = d;
    for (int i = 0; i < int'(NC); i++) begin
      if (rst) begin
        age[i] = DEF - 1; per[i] = DEF; pnd[i] = 0; pval[i] = 0; msc[i] = 0; mtk[i] = 0;
      end else if (e[i] && (s || age[i] == per[i] - 1)) begin
        age[i] = 0;
        if (l[i]) per[i] = clampv(int'(d));
        else if (pnd[i]) per[i] = clampv(pval[i]);
        pnd[i] = 0; msc[i] = 1; mtk[i] = 1;
      end else begin
        if (e[i]) begin
          age[i] = age[i] + 1;
          msc[i] = (age[i] < per[i] / 2);
        end
        mtk[i] = 0;
        if (l[i]) begin pnd[i] = 1; pval[i] = int'(d); end
      end
      x.sc[i] = msc[i]; x.tick[i] = mtk[i]; x.pend[i] = pnd[i];
    end
    exp_q.push_back(x);
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n, input logic [NC-1:0] e);
    for (int k = 0; k < n; k++) cycle(1'b0, e, 1'b0, '0, '0);
  endtask

  // Monitor: every clock the DUT presents a new output word
  initial begin
    exp_t x;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        n_chk++;
        if (sc !== x.sc) begin n_fail++; $display("FAIL sc t=%0t got=%b exp=%b", $time, sc, x.sc); end
        n_chk++;
        if (tick !== x.tick) begin n_fail++; $display("FAIL tick t=%0t got=%b exp=%b", $time, tick, x.tick); end
        n_chk++;
        if (pend !== x.pend) begin n_fail++; $display("FAIL pend t=%0t got=%b exp=%b", $time, pend, x.pend); end
      end
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < int'(NC); i++) begin
      age[i] = 0; per[i] = DEF; pval[i] = 0; pnd[i] = 0; msc[i] = 0; mtk[i] = 0;
    end
    // Reset then free-run at the default divisor
    cycle(1'b1, '0, 1'b0, '0, '0);
    cycle(1'b1, '0, 1'b0, '0, '0);
    idle(90, 2'b11);
    // Load 5 on channel 0 ten cycles into a period
    guard = 0;
    while (age[0] != 9 && guard < 100) begin idle(1, 2'b11); guard++; end
    cycle(1'b0, 2'b11, 1'b0, 2'b01, 16'd5);
    idle(60, 2'b11);
    // Divisors 0 and 1 clamp to 2
    cycle(1'b0, 2'b11, 1'b0, 2'b01, 16'd0);
    idle(20, 2'b11);
    cycle(1'b0, 2'b11, 1'b0, 2'b11, 16'd1);
    idle(50, 2'b11);
    cycle(1'b0, 2'b11, 1'b0, 2'b10, 16'd40);
    idle(90, 2'b11);
    // Pause channel 1 during its high phase
    guard = 0;
    while (age[1] != 3 && guard < 100) begin idle(1, 2'b11); guard++; end
    idle(7, 2'b01);
    idle(60, 2'b11);
    // Divisor 6 on channel 0, then sync at an arbitrary phase
    cycle(1'b0, 2'b11, 1'b0, 2'b01, 16'd6);
    idle(23, 2'b11);
    cycle(1'b0, 2'b11, 1'b1, '0, '0);
    idle(15, 2'b11);
    // Load coincident with a wrap on channel 0
    guard = 0;
    while (age[0] != per[0] - 1 && guard < 100) begin idle(1, 2'b11); guard++; end
    cycle(1'b0, 2'b11, 1'b0, 2'b01, 16'd9);
    idle(30, 2'b11);
    // Reset while a load is pending on a 5-cycle channel
    cycle(1'b0, 2'b11, 1'b0, 2'b01, 16'd5);
    idle(30, 2'b11);
    guard = 0;
    while (age[0] != 0 && guard < 100) begin idle(1, 2'b11); guard++; end
    cycle(1'b0, 2'b11, 1'b0, 2'b01, 16'd7);
    idle(1, 2'b11);
    cycle(1'b1, 2'b11, 1'b0, '0, '0);
    idle(90, 2'b11);
    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      logic          r_rst, r_sync;
      logic [NC-1:0] r_en, r_ld;
      logic [DW-1:0] r_d;
      r_rst  = ($urandom_range(0, 399) == 0);
      r_sync = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < int'(NC); i++) begin
        r_en[i] = ($urandom_range(0, 7) != 0);
        r_ld[i] = ($urandom_range(0, 39) == 0);
      end
      r_d = ($urandom_range(0, 9) == 0) ? DW'($urandom_range(13, 60)) : DW'($urandom_range(0, 12));
      cycle(r_rst, r_en, r_sync, r_ld, r_d);
    end
    idle(1, 2'b00);
    @(posedge clk); #3;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
